// File: rtl/ethernet_sys_dpram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ethernet_sys_dpram_ctrl_if
//  Description : Avalon-MM slave bundle for one port of the descriptor RAM.
//                The master modport is the bus-master view, the slave
//                modport is the RAM-controller view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ethernet_sys_dpram_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   logic [ADDR_W-1:0]   address;
   logic                read;
   logic                write;
   logic [DATA_W/8-1:0] byteenable;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   logic                waitrequest;

   modport master (
      output address, read, write, byteenable, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface
`default_nettype wire

// File: rtl/ethernet_sys_dpram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ethernet_sys_dpram_ctrl
//  Description : True-dual-port descriptor RAM with two Avalon-MM slaves on
//                one clock. Byte-lane writes, pipelined reads with
//                readdatavalid, mixed-port bypass returning new data,
//                merged same-address double writes (s1 wins per lane) with a
//                saturating collision counter, and a zero-clear sweep engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module ethernet_sys_dpram_ctrl #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 10,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   input  wire logic                  clear_req,
   output logic                       clear_busy,
   output logic [15:0]                collision_count,
   ethernet_sys_dpram_ctrl_if.slave   s1,
   ethernet_sys_dpram_ctrl_if.slave   s2
);

   localparam int                c_be_w      = DATA_W / 8;
   localparam int                c_depth     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] c_last_addr = '1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // Port bundling: index 0 is s1, index 1 is s2
   // ------------------------------------------------------------------------
   logic [1:0]                   w_rd;
   logic [1:0]                   w_wr;
   logic [1:0][ADDR_W-1:0]       w_addr;
   logic [1:0][c_be_w-1:0]       w_be;
   logic [1:0][DATA_W-1:0]       w_wd;
   logic [1:0][DATA_W-1:0]       w_rdata;
   logic [1:0]                   w_rvld;

   assign w_rd   = {s2.read,       s1.read};
   assign w_wr   = {s2.write,      s1.write};
   assign w_addr = {s2.address,    s1.address};
   assign w_be   = {s2.byteenable, s1.byteenable};
   assign w_wd   = {s2.writedata,  s1.writedata};

   assign s1.readdata      = w_rdata[0];
   assign s2.readdata      = w_rdata[1];
   assign s1.readdatavalid = w_rvld[0];
   assign s2.readdatavalid = w_rvld[1];

   // ------------------------------------------------------------------------
   // Acceptance: stall is purely registered state plus reset, never a
   // function of the incoming strobes.
   // ------------------------------------------------------------------------
   state_t            r_state;
   logic              r_busy;
   logic [ADDR_W-1:0] r_clr_addr;
   logic [15:0]       r_coll_cnt;

   logic       w_stall;
   logic [1:0] w_acc_wr;
   logic [1:0] w_acc_rd;
   logic       w_coll;
   logic       w_sweep;

   assign w_stall   = r_busy | reset;
   assign w_acc_wr  = w_wr & {2{~w_stall}};
   // A write on the same port wins; the simultaneous read is dropped.
   assign w_acc_rd  = w_rd & ~w_wr & {2{~w_stall}};
   assign w_coll    = (&w_acc_wr) & (w_addr[0] == w_addr[1]);
   assign w_sweep   = r_busy & ~reset;

   assign s1.waitrequest  = w_stall;
   assign s2.waitrequest  = w_stall;
   assign clear_busy      = r_busy;
   assign collision_count = r_coll_cnt;

   // ------------------------------------------------------------------------
   // Physical RAM port commands after sweep override and collision merge
   // ------------------------------------------------------------------------
   logic [1:0]             w_ram_we;
   logic [1:0][ADDR_W-1:0] w_ram_addr;
   logic [1:0][c_be_w-1:0] w_ram_be;
   logic [1:0][DATA_W-1:0] w_ram_wd;

   // Build RAM port commands: sweep owns port A, collisions fold s2 into port A.
   always_comb begin
      w_ram_we[0]   = w_acc_wr[0];
      w_ram_addr[0] = w_addr[0];
      w_ram_be[0]   = w_be[0];
      w_ram_wd[0]   = w_wd[0];
      if (w_coll) begin
         w_ram_be[0] = w_be[0] | w_be[1];
         for (int b = 0; b < c_be_w; b++) begin
            w_ram_wd[0][8*b +: 8] = w_be[0][b] ? w_wd[0][8*b +: 8] : w_wd[1][8*b +: 8];
         end
      end
      if (w_sweep) begin
         w_ram_we[0]   = 1'b1;
         w_ram_addr[0] = r_clr_addr;
         w_ram_be[0]   = '1;
         w_ram_wd[0]   = '0;
      end
      w_ram_we[1]   = w_acc_wr[1] & ~w_coll;
      w_ram_addr[1] = w_addr[1];
      w_ram_be[1]   = w_be[1];
      w_ram_wd[1]   = w_wd[1];
   end

   // ------------------------------------------------------------------------
   // Behavioural byte-enabled RAM (contents untouched by reset)
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] r_mem [0:c_depth-1];

   // Byte-lane writes from both RAM ports; merging guarantees distinct addresses.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (w_ram_we[p]) begin
            for (int b = 0; b < c_be_w; b++) begin
               if (w_ram_be[p][b]) begin
                  r_mem[w_ram_addr[p]][8*b +: 8] <= w_ram_wd[p][8*b +: 8];
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Per-port read pipeline with mixed-port bypass
   // ------------------------------------------------------------------------
   for (genvar p = 0; p < 2; p++) begin : g_port
      localparam int c_other = 1 - p;

      logic              r_vld1;
      logic [DATA_W-1:0] r_q;
      logic              r_byp;
      logic [DATA_W-1:0] r_byp_wd;
      logic [c_be_w-1:0] r_byp_be;
      logic [DATA_W-1:0] w_merged;

      // Capture RAM word plus the other port's same-address write; hold otherwise.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_vld1   <= 1'b0;
            r_q      <= '0;
            r_byp    <= 1'b0;
            r_byp_wd <= '0;
            r_byp_be <= '0;
         end else begin
            r_vld1 <= w_acc_rd[p];
            if (w_acc_rd[p]) begin
               r_q      <= r_mem[w_addr[p]];
               r_byp    <= w_ram_we[c_other] & (w_ram_addr[c_other] == w_addr[p]);
               r_byp_wd <= w_ram_wd[c_other];
               r_byp_be <= w_ram_be[c_other];
            end
         end
      end

      // Overlay freshly written lanes on the old RAM word.
      always_comb begin
         w_merged = r_q;
         for (int b = 0; b < c_be_w; b++) begin
            if (r_byp && r_byp_be[b]) begin
               w_merged[8*b +: 8] = r_byp_wd[8*b +: 8];
            end
         end
      end

      if (OUT_REG != 0) begin : g_out_reg
         logic              r_vld2;
         logic [DATA_W-1:0] r_dout;

         // Second stage; data only moves on a valid so it holds between pulses.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_vld2 <= 1'b0;
               r_dout <= '0;
            end else begin
               r_vld2 <= r_vld1;
               if (r_vld1) begin
                  r_dout <= w_merged;
               end
            end
         end

         assign w_rdata[p] = r_dout;
         assign w_rvld[p]  = r_vld2;
      end else begin : g_no_reg
         assign w_rdata[p] = w_merged;
         assign w_rvld[p]  = r_vld1;
      end
   end

   // ------------------------------------------------------------------------
   // Collision counter
   // ------------------------------------------------------------------------
   // Count merged double writes, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_coll_cnt <= '0;
      end else if (w_coll && (r_coll_cnt != 16'hFFFF)) begin
         r_coll_cnt <= r_coll_cnt + 16'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Clear engine: IDLE -> CLEAR (one word per cycle) -> IDLE
   // ------------------------------------------------------------------------
   // Sweep FSM; reset parks it at address 0, armed or idle by configuration.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clr_addr <= '0;
         if (CLEAR_ON_RESET != 0) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
         end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (clear_req) begin
                  r_state    <= ST_CLEAR;
                  r_busy     <= 1'b1;
                  r_clr_addr <= '0;
               end
            end
            ST_CLEAR: begin
               r_clr_addr <= r_clr_addr + 1'b1;
               if (r_clr_addr == c_last_addr) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ethernet_sys_dpram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ethernet_sys_dpram_ctrl
//  Description : Scoreboard bench for the dual-port descriptor RAM controller.
//                A byte-lane memory model predicts read data and return cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ethernet_sys_dpram_ctrl;

   localparam int DATA_W         = 32;
   localparam int ADDR_W         = 4;
   localparam int OUT_REG        = 1;
   localparam int CLEAR_ON_RESET = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear_req = 1'b0;
   logic        clear_busy;
   logic [15:0] collision_count;

   ethernet_sys_dpram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s1 ();
   ethernet_sys_dpram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s2 ();

   ethernet_sys_dpram_ctrl #(
      .DATA_W         (DATA_W),
      .ADDR_W         (ADDR_W),
      .OUT_REG        (OUT_REG),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .clear_req       (clear_req),
      .clear_busy      (clear_busy),
      .collision_count (collision_count),
      .s1              (s1),
      .s2              (s2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        q1[$];
   exp_t        q2[$];
   logic [31:0] model [16];
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;
   int          exp_coll = 0;

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // Scoreboard monitor for one port, sampled at the falling edge.
   task automatic mon(input int p);
      logic        v;
      logic [31:0] d;
      exp_t        e;
      if (p == 1) begin v = s1.readdatavalid; d = s1.readdata; end
      else        begin v = s2.readdatavalid; d = s2.readdata; end
      if (v === 1'b1) begin
         n_vec++;
         if ((p == 1 && q1.size() == 0) || (p == 2 && q2.size() == 0)) begin
            n_err++;
            $display("FAIL stray_valid s%0d cyc %0d: got pulse data=%h, required no pulse", p, cyc, d);
         end else begin
            e = (p == 1) ? q1.pop_front() : q2.pop_front();
            if (d !== e.data || cyc !== e.cyc) begin
               n_err++;
               $display("FAIL read_s%0d: got data=%h at cyc %0d, required %h at cyc %0d",
                        p, d, cyc, e.data, e.cyc);
            end
         end
      end else if (v !== 1'b0) begin
         n_vec++;
         n_err++;
         $display("FAIL valid_x_s%0d cyc %0d: got %b, required 0/1", p, cyc, v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      mon(1);
      mon(2);
   endtask

   task automatic idle_bus();
      s1.read = 1'b0; s1.write = 1'b0;
      s2.read = 1'b0; s2.write = 1'b0;
   endtask

   // Drive one cycle of commands on both ports, predict outcome, then clock.
   task automatic cmd(input logic r1, input logic w1, input logic [3:0] a1,
                      input logic [3:0] be1, input logic [31:0] d1,
                      input logic r2, input logic w2, input logic [3:0] a2,
                      input logic [3:0] be2, input logic [31:0] d2);
      exp_t e;
      s1.read = r1; s1.write = w1; s1.address = a1; s1.byteenable = be1; s1.writedata = d1;
      s2.read = r2; s2.write = w2; s2.address = a2; s2.byteenable = be2; s2.writedata = d2;
      if (s1.waitrequest === 1'b0) begin
         if (r1 && !w1) begin
            e.data = model[a1];
            if (w2 && a2 == a1) e.data = merge(e.data, d2, be2);
            e.cyc = cyc + 1 + OUT_REG;
            q1.push_back(e);
         end
         if (r2 && !w2) begin
            e.data = model[a2];
            if (w1 && a1 == a2) e.data = merge(e.data, d1, be1);
            e.cyc = cyc + 1 + OUT_REG;
            q2.push_back(e);
         end
         if (w2) model[a2] = merge(model[a2], d2, be2);
         if (w1) model[a1] = merge(model[a1], d1, be1);
         if (w1 && w2 && a1 == a2) exp_coll++;
      end
      step();
      idle_bus();
   endtask

   task automatic wait_sweep(input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (clear_busy === 1'b1 && n < 40);
      n_vec++;
      if (n !== 16) begin
         n_err++;
         $display("FAIL %s: clear_busy high %0d cycles after start, required 16", name, n);
      end
      for (int i = 0; i < 16; i++) model[i] = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      q1.delete(); q2.delete();
      repeat (3) step();
      n_vec++;
      if (s1.readdata !== 32'h0 || s2.readdata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_readdata: got %h/%h, required 0/0", s1.readdata, s2.readdata);
      end
      n_vec++;
      if (collision_count !== 16'h0) begin
         n_err++;
         $display("FAIL reset_coll: got %0d, required 0", collision_count);
      end
      n_vec++;
      if (clear_busy !== 1'b1 || s1.waitrequest !== 1'b1 || s2.waitrequest !== 1'b1) begin
         n_err++;
         $display("FAIL reset_busy: got busy=%b wr=%b/%b, required 1/1/1",
                  clear_busy, s1.waitrequest, s2.waitrequest);
      end
      reset = 1'b0;
      wait_sweep("reset_sweep_len");
      n_vec++;
      if (s1.waitrequest !== 1'b0 || s2.waitrequest !== 1'b0) begin
         n_err++;
         $display("FAIL post_sweep_wr: got %b/%b, required 0/0", s1.waitrequest, s2.waitrequest);
      end
      cmd(1, 0, 4'd5, 4'h0, 0, 1, 0, 4'd10, 4'h0, 0);
      repeat (3) step();
   endtask

   task automatic test_cross_port();
      cmd(0, 1, 4'd3, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      cmd(0, 0, 0, 0, 0, 1, 0, 4'd3, 4'h0, 0);
      cmd(0, 0, 0, 0, 0, 0, 1, 4'd4, 4'hF, 32'hCAFEF00D);
      cmd(1, 0, 4'd4, 4'h0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
   endtask

   task automatic test_collision();
      cmd(0, 1, 4'd7, 4'b0011, 32'h11111111, 0, 1, 4'd7, 4'b0110, 32'h22222222);
      n_vec++;
      if (collision_count !== 16'd1) begin
         n_err++;
         $display("FAIL coll_count: got %0d, required 1", collision_count);
      end
      cmd(1, 0, 4'd7, 4'h0, 0, 1, 0, 4'd7, 4'h0, 0);
      cmd(0, 1, 4'd13, 4'hF, 32'h01010101, 0, 1, 4'd14, 4'hF, 32'h02020202);
      n_vec++;
      if (collision_count !== exp_coll[15:0]) begin
         n_err++;
         $display("FAIL coll_distinct: got %0d, required %0d", collision_count, exp_coll);
      end
      cmd(1, 0, 4'd14, 4'h0, 0, 1, 0, 4'd13, 4'h0, 0);
      repeat (3) step();
   endtask

   task automatic test_bypass();
      cmd(0, 1, 4'd9, 4'hF, 32'h12345678, 0, 1, 4'd11, 4'hF, 32'h55667788);
      cmd(1, 0, 4'd9, 4'h0, 0, 0, 1, 4'd9, 4'b1100, 32'hAABBCCDD);
      cmd(0, 1, 4'd11, 4'b0101, 32'h0F0F0F0F, 1, 0, 4'd11, 4'h0, 0);
      cmd(1, 0, 4'd11, 4'h0, 0, 1, 0, 4'd9, 4'h0, 0);
      repeat (3) step();
   endtask

   task automatic test_same_port_rw();
      cmd(1, 1, 4'd2, 4'hF, 32'h01020304, 0, 0, 0, 0, 0);
      repeat (3) step();
      cmd(1, 0, 4'd2, 4'h0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++)
         cmd(0, 0, 0, 0, 0, 0, 1, 4'(i), 4'hF, 32'hA0000000 + 32'(i) * 32'h01010101);
      for (int i = 0; i < 8; i++)
         cmd(1, 0, 4'(i), 4'h0, 0, 1, 0, 4'(7 - i), 4'h0, 0);
      repeat (5) step();
      n_vec++;
      if (s1.readdata !== model[7] || s2.readdata !== model[0]) begin
         n_err++;
         $display("FAIL hold_readdata: got %h/%h, required %h/%h",
                  s1.readdata, s2.readdata, model[7], model[0]);
      end
      n_vec++;
      if (q1.size() != 0 || q2.size() != 0) begin
         n_err++;
         $display("FAIL b2b_pending: got %0d/%0d outstanding, required 0/0", q1.size(), q2.size());
      end
   endtask

   task automatic test_clear_req();
      int n;
      cmd(0, 1, 4'd15, 4'hF, 32'h00000077, 0, 0, 0, 0, 0);
      clear_req = 1'b1;
      cmd(1, 0, 4'd15, 4'h0, 0, 0, 0, 0, 0, 0);
      clear_req = 1'b0;
      n = 0;
      do begin
         clear_req = (n == 4);
         step();
         n++;
      end while (clear_busy === 1'b1 && n < 40);
      clear_req = 1'b0;
      n_vec++;
      if (n !== 16) begin
         n_err++;
         $display("FAIL clear_req_len: got %0d busy cycles, required 16", n);
      end
      for (int i = 0; i < 16; i++) model[i] = '0;
      cmd(1, 0, 4'd15, 4'h0, 0, 1, 0, 4'd3, 4'h0, 0);
      repeat (3) step();
   endtask

   task automatic test_reset_mid_sweep();
      cmd(0, 1, 4'd12, 4'hF, 32'h99999999, 0, 0, 0, 0, 0);
      cmd(1, 0, 4'd12, 4'h0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      q1.delete(); q2.delete();
      step();
      reset = 1'b0;
      wait_sweep("inflight_reset_sweep");
      cmd(0, 1, 4'd12, 4'hF, 32'h99999999, 0, 1, 4'd8, 4'hF, 32'h88888888);
      clear_req = 1'b1;
      cmd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      clear_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         clear_req = (i == 2);
         step();
      end
      clear_req = 1'b0;
      reset = 1'b1;
      q1.delete(); q2.delete();
      step();
      reset = 1'b0;
      wait_sweep("restart_sweep_len");
      cmd(1, 0, 4'd12, 4'h0, 0, 1, 0, 4'd8, 4'h0, 0);
      cmd(1, 0, 4'd6, 4'h0, 0, 0, 0, 0, 0, 0);
      repeat (4) step();
      n_vec++;
      if (q1.size() != 0 || q2.size() != 0) begin
         n_err++;
         $display("FAIL final_pending: got %0d/%0d outstanding, required 0/0", q1.size(), q2.size());
      end
   endtask

   initial begin
      s1.address = '0; s1.byteenable = '0; s1.writedata = '0;
      s2.address = '0; s2.byteenable = '0; s2.writedata = '0;
      idle_bus();
      test_reset();
      test_cross_port();
      test_collision();
      test_bypass();
      test_same_port_rw();
      test_back_to_back();
      test_clear_req();
      test_reset_mid_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
